// File: rtl/hc8_ram_arbiter_pkg.sv
// Shared definitions for the HC8 data-RAM arbiter: default geometry and FSM state encodings.
package hc8_pkg;

  localparam int unsigned ADDR_W_DEF    = 8;
  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_st_e;

  function automatic arb_st_e own_state(input logic port);
    return port ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/hc8_ram_arbiter_if.sv
// One requester's view of the shared data RAM: request/address/data in, grant/read data out.
interface hc8_ram_arbiter_if
  import hc8_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              stall;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, stall, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, stall, rvalid, rdata
  );

endinterface

// File: rtl/hc8_ram_sp.sv
// Synchronous single-port RAM with a registered read; contents are never reset.
module hc8_ram_sp
  import hc8_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port and read-first registered read on the same address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/hc8_ram_arbiter.sv
// Round-robin arbiter with a burst limit sharing the HC8 data RAM between the CPU (p0)
// and the loader/debug port (p1); grants are same-cycle, read data follows one cycle later.
module hc8_ram_arbiter
  import hc8_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic               clk,
  input  logic               Reset,
  hc8_ram_arbiter_if.slave   p0,
  hc8_ram_arbiter_if.slave   p1
);

  localparam int unsigned    CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  arb_st_e           st_r,   st_nxt_s;
  logic [CNT_W-1:0]  cnt_r,  cnt_nxt_s;
  logic              last_r, last_nxt_s;
  logic              grant_s;
  logic              sel_s;

  logic              rvalid0_r, rvalid1_r;
  logic              rvalid0_s, rvalid1_s;
  logic [DATA_W-1:0] hold0_r,   hold1_r;
  logic [DATA_W-1:0] ram_rdata_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;

  // Winner selection and next-state: the owner keeps the RAM until its burst is spent
  // and the other port is waiting.
  always_comb begin
    grant_s    = 1'b0;
    sel_s      = 1'b0;
    st_nxt_s   = ST_IDLE;
    cnt_nxt_s  = CNT_ZERO;
    last_nxt_s = last_r;

    case (st_r)
      ST_IDLE: begin
        if (p0.req && p1.req) begin
          grant_s = 1'b1;
          sel_s   = ~last_r;
        end else if (p0.req) begin
          grant_s = 1'b1;
          sel_s   = 1'b0;
        end else if (p1.req) begin
          grant_s = 1'b1;
          sel_s   = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
      end
      ST_OWN0: begin
        if (p0.req && ((cnt_r < CNT_MAX) || !p1.req)) begin
          grant_s = 1'b1;
          sel_s   = 1'b0;
        end else if (p1.req) begin
          grant_s = 1'b1;
          sel_s   = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
      end
      ST_OWN1: begin
        if (p1.req && ((cnt_r < CNT_MAX) || !p0.req)) begin
          grant_s = 1'b1;
          sel_s   = 1'b1;
        end else if (p0.req) begin
          grant_s = 1'b1;
          sel_s   = 1'b0;
        end else begin
          grant_s = 1'b0;
        end
      end
      default: begin
        grant_s = 1'b0;
      end
    endcase

    // Requests during reset are dropped, not queued.
    if (Reset) begin
      grant_s = 1'b0;
    end else begin
      grant_s = grant_s;
    end

    if (grant_s) begin
      st_nxt_s   = own_state(sel_s);
      last_nxt_s = sel_s;
      if (st_r == own_state(sel_s)) begin
        if (cnt_r < CNT_MAX) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = CNT_MAX;
        end
      end else begin
        cnt_nxt_s = CNT_ONE;
      end
    end else begin
      st_nxt_s  = ST_IDLE;
      cnt_nxt_s = CNT_ZERO;
    end
  end

  // Arbiter state register; port 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      st_r   <= ST_IDLE;
      cnt_r  <= CNT_ZERO;
      last_r <= 1'b1;
    end else begin
      st_r   <= st_nxt_s;
      cnt_r  <= cnt_nxt_s;
      last_r <= last_nxt_s;
    end
  end

  assign ram_addr_s  = sel_s ? p1.addr  : p0.addr;
  assign ram_wdata_s = sel_s ? p1.wdata : p0.wdata;
  assign ram_we_s    = grant_s & (sel_s ? p1.we : p0.we);

  hc8_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Read-valid pipeline and per-port hold of the last delivered word.
  always_ff @(posedge clk) begin
    if (Reset) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      hold0_r   <= {DATA_W{1'b0}};
      hold1_r   <= {DATA_W{1'b0}};
    end else begin
      rvalid0_r <= grant_s & ~sel_s & ~p0.we;
      rvalid1_r <= grant_s &  sel_s & ~p1.we;
      if (rvalid0_s) begin
        hold0_r <= ram_rdata_s;
      end
      if (rvalid1_s) begin
        hold1_r <= ram_rdata_s;
      end
    end
  end

  // A read granted just before reset must not surface while reset is asserted.
  assign rvalid0_s = rvalid0_r & ~Reset;
  assign rvalid1_s = rvalid1_r & ~Reset;

  assign p0.gnt    = grant_s & ~sel_s;
  assign p1.gnt    = grant_s &  sel_s;
  assign p0.stall  = p0.req & ~(grant_s & ~sel_s);
  assign p1.stall  = p1.req & ~(grant_s &  sel_s);
  assign p0.rvalid = rvalid0_s;
  assign p1.rvalid = rvalid1_s;
  assign p0.rdata  = rvalid0_s ? ram_rdata_s : hold0_r;
  assign p1.rdata  = rvalid1_s ? ram_rdata_s : hold1_r;

endmodule

// File: tb/tb_hc8_ram_arbiter.sv
// Bench for hc8_ram_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_hc8_ram_arbiter;
  import hc8_pkg::*;

  localparam int MB = 4;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  hc8_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p0 ();
  hc8_ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) p1 ();

  hc8_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .Reset (Reset),
    .p0    (p0),
    .p1    (p1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // behavioural model state
  int         prev_port = -1;
  int         streak    = 0;
  int         last      = 1;
  bit         model_ok  = 1'b0;
  bit         pend_rv [2];
  logic [7:0] pend_d  [2];
  logic [7:0] hold    [2];
  logic [7:0] mem_m   [256];

  // last sampled DUT outputs
  logic       obs_g0, obs_g1, obs_s0, obs_s1, obs_rv0, obs_rv1;
  logic [7:0] obs_rd0, obs_rd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int winner(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (prev_port < 0) return 1 - last;
    if (streak >= MB)  return 1 - prev_port;
    return prev_port;
  endfunction

  task automatic step(input bit rst,
                      input bit r0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                      input bit r1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    int         w;
    bit         eg0, eg1, erv0, erv1;
    logic [7:0] erd0, erd1;
    @(negedge clk);
    Reset = rst;
    p0.req = r0; p0.we = w0; p0.addr = a0; p0.wdata = d0;
    p1.req = r1; p1.we = w1; p1.addr = a1; p1.wdata = d1;
    #1;
    w    = rst ? -1 : winner(r0, r1);
    eg0  = (w == 0);
    eg1  = (w == 1);
    erv0 = pend_rv[0] && !rst;
    erv1 = pend_rv[1] && !rst;
    erd0 = erv0 ? pend_d[0] : hold[0];
    erd1 = erv1 ? pend_d[1] : hold[1];
    obs_g0 = p0.gnt;    obs_g1 = p1.gnt;
    obs_s0 = p0.stall;  obs_s1 = p1.stall;
    obs_rv0 = p0.rvalid; obs_rv1 = p1.rvalid;
    obs_rd0 = p0.rdata;  obs_rd1 = p1.rdata;
    chk("gnt0",   32'(obs_g0), 32'(eg0));
    chk("gnt1",   32'(obs_g1), 32'(eg1));
    chk("stall0", 32'(obs_s0), 32'(r0 && !eg0));
    chk("stall1", 32'(obs_s1), 32'(r1 && !eg1));
    if (model_ok) begin
      chk("rvalid0", 32'(obs_rv0), 32'(erv0));
      chk("rvalid1", 32'(obs_rv1), 32'(erv1));
      chk("rdata0",  32'(obs_rd0), 32'(erd0));
      chk("rdata1",  32'(obs_rd1), 32'(erd1));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      prev_port = -1; streak = 0; last = 1; model_ok = 1'b1;
      pend_rv[0] = 1'b0; pend_rv[1] = 1'b0;
      hold[0] = 8'h00;   hold[1] = 8'h00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (pend_rv[p]) hold[p] = pend_d[p];
        pend_rv[p] = 1'b0;
      end
      if (w >= 0) begin
        if (w == 0) begin
          if (w0) mem_m[a0] = d0;
          else begin pend_rv[0] = 1'b1; pend_d[0] = mem_m[a0]; end
        end else begin
          if (w1) mem_m[a1] = d1;
          else begin pend_rv[1] = 1'b1; pend_d[1] = mem_m[a1]; end
        end
        streak    = (w == prev_port) ? streak + 1 : 1;
        prev_port = w;
        last      = w;
      end else begin
        prev_port = -1;
        streak    = 0;
      end
    end
  endtask

  int exp4 [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    // reset held two cycles with both ports requesting
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("t1_gnt0", 32'(obs_g0), 32'd0);
    chk("t1_gnt1", 32'(obs_g1), 32'd0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
    chk("t1_rvalid0", 32'(obs_rv0), 32'd0);
    chk("t1_rvalid1", 32'(obs_rv1), 32'd0);
    chk("t1_rdata0",  32'(obs_rd0), 32'd0);
    chk("t1_rdata1",  32'(obs_rd1), 32'd0);

    // both ports writing continuously: first tie to port 0, then bursts of MB
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(i), 8'(i + 1), 1'b1, 1'b1, 8'(8'h80 + i), 8'(i + 2));
      if (i == 0) begin
        chk("t3_gnt0",   32'(obs_g0), 32'd1);
        chk("t3_gnt1",   32'(obs_g1), 32'd0);
        chk("t3_stall0", 32'(obs_s0), 32'd0);
        chk("t3_stall1", 32'(obs_s1), 32'd1);
      end
      chk("t4_seq", 32'(obs_g1), 32'(exp4[i]));
      chk("t4_one", 32'(obs_g0 ^ obs_g1), 32'd1);
    end

    // port 0 alone keeps the RAM, then yields once port 1 shows up
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i), 1'b0, 1'b0, 8'h00, 8'h00);
      chk("t5_solo", 32'(obs_g0), 32'd1);
    end
    step(1'b0, 1'b1, 1'b1, 8'h50, 8'h11, 1'b1, 1'b1, 8'h51, 8'h22);
    chk("t5_gnt1",   32'(obs_g1), 32'd1);
    chk("t5_stall0", 32'(obs_s0), 32'd1);

    // write then read back through port 0
    step(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2_rdgnt", 32'(obs_g0), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2_rvalid", 32'(obs_rv0), 32'd1);
    chk("t2_rdata",  32'(obs_rd0), 32'h5A);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t2_oneshot", 32'(obs_rv0), 32'd0);
    chk("t2_hold",    32'(obs_rd0), 32'h5A);

    // port 1 read cut off by reset; RAM survives reset
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h33);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    chk("t6_rdgnt", 32'(obs_g1), 32'd1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t6_rv_n1", 32'(obs_rv1), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t6_rv_n2", 32'(obs_rv1), 32'd0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t6_rvalid", 32'(obs_rv1), 32'd1);
    chk("t6_rdata",  32'(obs_rd1), 32'h33);

    // preload every word so random reads have known contents
    for (int a = 0; a < 256; a++) begin
      step(1'b0, 1'b1, 1'b1, 8'(a), 8'($urandom), 1'b0, 1'b0, 8'h00, 8'h00);
    end

    // random mixed traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
